// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Iterative signed multiply / divide engine with its own sequencer, used by
// the multicycle MIPS core for MULT, DIV and DIVM. The control unit issues a
// one-cycle start, then waits on busy/done; the HI/LO pair comes back
// registered together with write strobes.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_in   in   asynchronous active-low reset
//   start      in   request pulse, only sampled while idle
//   op         in   00 none, 01 MULT, 10 DIV, 11 DIVM (DIVM computed as DIV)
//   opA, opB   in   signed operands (multiplicand/dividend, multiplier/divisor)
//   busy       out  operation in progress
//   done       out  one-cycle completion pulse
//   hi, lo     out  MULT: upper/lower product; DIV: remainder/quotient
//   hi_w, lo_w out  HI/LO write strobes, coincident with a successful done
//   div_zero   out  coincident with done when the divisor was zero
//   state_dbg  out  current FSM state (IDLE=0, CALC=1, FIX=2, DONE=3)
//
// Handshake: a request is taken on any rising edge where the engine is idle,
// start=1 and op!=00; there is no ready signal, so a start seen while busy is
// simply dropped (no queuing). Completion is signalled by exactly one done
// cycle; busy drops on the following edge.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_in,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hi_w,
  output logic             lo_w,
  output logic             div_zero,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // MULT: {partial product high, remaining multiplier bits}.
  // DIV : low half holds the dividend shifting out / quotient shifting in.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     rem_q, rem_d;      // DIV partial remainder (always < divisor)
  logic [WIDTH-1:0]     mag_q, mag_d;      // MULT multiplicand / DIV divisor magnitude
  logic                 is_mul_q, is_mul_d;
  logic                 sign_res_q, sign_res_d;
  logic                 sign_a_q, sign_a_d;

  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 hi_w_q, hi_w_d;
  logic                 lo_w_q, lo_w_d;
  logic                 div_zero_q, div_zero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  logic [WIDTH-1:0]     abs_a, abs_b;
  assign abs_a = opA[WIDTH-1] ? (~opA + 1'b1) : opA;
  assign abs_b = opB[WIDTH-1] ? (~opB + 1'b1) : opB;

  // Shift-add step: add the multiplicand into the high half when the current
  // multiplier bit is set, keep the carry, then shift the whole accumulator
  // right by one.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mag_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                             : {1'b0, acc_q[2*WIDTH-1:1]};

  // Restoring step: bring in the next dividend bit, trial-subtract the
  // divisor in WIDTH+1 bits and keep the result only if it did not borrow.
  logic [WIDTH:0]       div_shift;
  logic [WIDTH:0]       div_trial;
  logic                 div_ok;
  logic [WIDTH:0]       rem_next;
  logic [WIDTH-1:0]     quo_next;
  assign div_shift = {rem_q, acc_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, mag_q};
  assign div_ok    = ~div_trial[WIDTH];
  assign rem_next  = div_ok ? div_trial : div_shift;
  assign quo_next  = {acc_q[WIDTH-2:0], div_ok};

  // Sign correction applied in FIX. The remainder follows the dividend's sign.
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  assign prod_fix = sign_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = sign_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = sign_a_q ? (~rem_q + 1'b1) : rem_q;

  logic                 cnt_last;
  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      mag_q      <= '0;
      is_mul_q   <= 1'b0;
      sign_res_q <= 1'b0;
      sign_a_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hi_w_q     <= 1'b0;
      lo_w_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      rem_q      <= rem_d;
      mag_q      <= mag_d;
      is_mul_q   <= is_mul_d;
      sign_res_q <= sign_res_d;
      sign_a_q   <= sign_a_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hi_w_q     <= hi_w_d;
      lo_w_q     <= lo_w_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    rem_d      = rem_q;
    mag_d      = mag_q;
    is_mul_d   = is_mul_q;
    sign_res_d = sign_res_q;
    sign_a_d   = sign_a_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hi_w_d     = 1'b0;
    lo_w_d     = 1'b0;
    div_zero_d = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && (op != 2'b00)) begin
          busy_d     = 1'b1;
          is_mul_d   = (op == 2'b01);
          sign_a_d   = opA[WIDTH-1];
          sign_res_d = opA[WIDTH-1] ^ opB[WIDTH-1];
          cnt_d      = '0;
          rem_d      = '0;
          if (op == 2'b01) begin
            mag_d = abs_a;
            acc_d = {{WIDTH{1'b0}}, abs_b};
          end else begin
            mag_d = abs_b;
            acc_d = {{WIDTH{1'b0}}, abs_a};
          end
          if (op[1] && (opB == '0)) begin
            // Divide by zero: report immediately, leave HI/LO untouched.
            state_d    = DONE;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (is_mul_q) begin
          acc_d = mul_next;
        end else begin
          acc_d = {acc_q[2*WIDTH-1:WIDTH], quo_next};
          rem_d = rem_next[WIDTH-1:0];
        end
        if (cnt_last) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (is_mul_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        done_d  = 1'b1;
        hi_w_d  = 1'b1;
        lo_w_d  = 1'b1;
        state_d = DONE;
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign hi_w      = hi_w_q;
  assign lo_w      = lo_w_q;
  assign div_zero  = div_zero_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;
  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic         clk      = 1'b0;
  logic         reset_in = 1'b1;
  logic         start    = 1'b0;
  logic [1:0]   op       = 2'b00;
  logic [W-1:0] opA      = '0;
  logic [W-1:0] opB      = '0;

  logic         busy, done, hi_w, lo_w, div_zero;
  logic [W-1:0] hi, lo;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk       (clk),
    .reset_in  (reset_in),
    .start     (start),
    .op        (op),
    .opA       (opA),
    .opB       (opB),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .hi_w      (hi_w),
    .lo_w      (lo_w),
    .div_zero  (div_zero),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed reference arithmetic: full 64-bit product, truncating division
  // with remainder carrying the dividend's sign.
  function automatic void ref_calc(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b01) begin
      p  = sa * sb;
      rh = p[63:32];
      rl = p[31:0];
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      rh = r[31:0];
      rl = q[31:0];
    end
  endfunction

  // Behavioural model: tracks how many edges remain until the engine is
  // free again and what result is pending delivery.
  logic         m_busy = 0, m_done = 0, m_hiw = 0, m_low = 0, m_dz = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
  int           m_rem = 0;
  logic [W-1:0] exp_q[$];

  initial begin
    forever begin
      @(posedge clk or negedge reset_in);
      if (!reset_in) begin
        m_busy = 0; m_done = 0; m_hiw = 0; m_low = 0; m_dz = 0;
        m_hi = '0; m_lo = '0; m_rem = 0;
      end else if (m_rem == 0) begin
        m_busy = 0; m_done = 0; m_hiw = 0; m_low = 0; m_dz = 0;
        if (start && op != 2'b00) begin
          m_busy = 1;
          if (op[1] && opB == '0) begin
            m_done = 1;
            m_dz   = 1;
            m_rem  = 1;
          end else begin
            ref_calc(op, opA, opB, m_pend_hi, m_pend_lo);
            m_rem = W + 2;
          end
        end
      end else begin
        m_rem--;
        if (m_rem == 1) begin
          m_done = 1; m_hiw = 1; m_low = 1;
          m_hi = m_pend_hi; m_lo = m_pend_lo;
        end else if (m_rem == 0) begin
          m_busy = 0; m_done = 0; m_hiw = 0; m_low = 0; m_dz = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      check("busy",     {31'b0, busy},     {31'b0, m_busy});
      check("done",     {31'b0, done},     {31'b0, m_done});
      check("hi_w",     {31'b0, hi_w},     {31'b0, m_hiw});
      check("lo_w",     {31'b0, lo_w},     {31'b0, m_low});
      check("div_zero", {31'b0, div_zero}, {31'b0, m_dz});
      check("hi",       hi,                m_hi);
      check("lo",       lo,                m_lo);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns 1ns after the edge that samples the request.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk);
    #1;
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    op  = 2'($urandom_range(0, 3));
    opA = $urandom;
    opB = $urandom;
  endtask

  // Directed operation with literal expectations that pin the model.
  task automatic directed(input string name, input logic [1:0] o,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] e_hi, input logic [W-1:0] e_lo);
    issue(o, a, b);
    wait_edges(32);
    check({name, "_early_done"}, {31'b0, done}, 32'd0);
    wait_edges(1);
    exp_q.push_back(e_hi);
    exp_q.push_back(e_lo);
    check({name, "_done"}, {31'b0, done}, 32'd1);
    check({name, "_hi_w"}, {31'b0, hi_w}, 32'd1);
    check({name, "_hi"}, hi, exp_q.pop_front());
    check({name, "_lo"}, lo, exp_q.pop_front());
    wait_edges(1);
    check({name, "_busy_off"}, {31'b0, busy}, 32'd0);
  endtask

  logic [W-1:0] ra, rb;
  logic [1:0]   ro;

  initial begin
    #1 reset_in = 1'b0;
    #11;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_hi",   hi, 32'd0);
    check("rst_lo",   lo, 32'd0);
    @(posedge clk);
    #1 reset_in = 1'b1;

    directed("mul_7_m3",  2'b01, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
    directed("mul_min",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    directed("mul_m1",    2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
    directed("div_m7_2",  2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    directed("divm_100",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
    directed("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);

    // Divide by zero: immediate done, strobes low, HI/LO unchanged.
    issue(2'b10, 32'd5, 32'd0);
    check("dz_done", {31'b0, done},     32'd1);
    check("dz_flag", {31'b0, div_zero}, 32'd1);
    check("dz_hi_w", {31'b0, hi_w},     32'd0);
    check("dz_hi",   hi, 32'h00000000);
    check("dz_lo",   lo, 32'h80000000);
    wait_edges(1);
    check("dz_busy_off", {31'b0, busy}, 32'd0);
    check("dz_flag_off", {31'b0, div_zero}, 32'd0);

    // Start while busy is dropped; the MULT still finishes on time.
    issue(2'b01, 32'd3, 32'd5);
    wait_edges(9);
    start = 1'b1; op = 2'b10; opA = 32'd100; opB = 32'd3;
    wait_edges(1);
    start = 1'b0;
    wait_edges(23);
    check("busy_ign_done", {31'b0, done}, 32'd1);
    check("busy_ign_lo",   lo, 32'd15);
    check("busy_ign_hi",   hi, 32'd0);
    wait_edges(2);

    // op=00 start is ignored.
    issue(2'b00, 32'd1, 32'd1);
    check("nop_busy", {31'b0, busy}, 32'd0);
    wait_edges(2);
    check("nop_busy2", {31'b0, busy}, 32'd0);

    // Asynchronous reset mid-CALC.
    issue(2'b01, 32'd9, 32'd9);
    wait_edges(14);
    #2 reset_in = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_hi",   hi, 32'd0);
    check("arst_lo",   lo, 32'd0);
    wait_edges(3);
    reset_in = 1'b1;
    directed("mul_3_4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12);

    // Randomized traffic, including stray starts while busy.
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h80000000;
        1: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        2: rb = 32'd1;
        3: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
      for (int i = 0; i < W + 3; i++) begin
        if (i < W && $urandom_range(0, 7) == 0) begin
          start = 1'b1;
          op    = 2'($urandom_range(1, 3));
          opA   = $urandom;
          opB   = $urandom;
        end else begin
          start = 1'b0;
        end
        wait_edges(1);
      end
      start = 1'b0;
      wait_edges(W + 3);
    end

    wait_edges(4);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide engine plus its sequencer for the multicycle MIPS core.
- Accepts a one-cycle start from the main control unit for MULT, DIV or DIVM, runs a fixed-length shift-add / restoring-divide loop, and returns a registered HI/LO pair.
- Provides HI/LO write strobes, a done pulse and a divide-by-zero flag.
- The control unit waits on busy/done instead of counting cycles itself.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH each.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset_in  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- op  in  2  00 none, 01 MULT, 10 DIV, 11 DIVM. DIVM is computed exactly as DIV; the caller has already supplied memory operands.
- opA  in  WIDTH  multiplicand / dividend (signed).
- opB  in  WIDTH  multiplier / divisor (signed).
- busy  out  1  high from the cycle after start is accepted until the cycle after done.
- done  out  1  one-cycle completion pulse.
- hi  out  WIDTH  MULT: upper product; DIV: remainder.
- lo  out  WIDTH  MULT: lower product; DIV: quotient.
- hi_w  out  1  HI register write strobe; coincident with done on success.
- lo_w  out  1  LO register write strobe; coincident with done on success.
- div_zero  out  1  coincident with done when the divisor is 0.

Behaviour:
- Reset (reset_in=0, any time, asynchronous):
  - State goes to IDLE; counter is 0.
  - busy, done, hi_w, lo_w, div_zero are 0; hi and lo are 0.
  - An operation in flight is discarded with no done pulse.
- All outputs are registered.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 with op≠00 at edge E0:
    - Latch |opA|, |opB|, result sign (sA^sB) and dividend sign (sA).
    - Clear the counter; go to CALC; busy=1.
  - start with op=00 is ignored.
  - DIV/DIVM with opB==0 at E0:
    - Go straight to DONE with div_zero=1, done=1, hi_w=lo_w=0.
    - hi and lo keep their previous values.
- CALC, exactly WIDTH cycles, counter 0..WIDTH-1:
  - MULT: unsigned shift-add on magnitudes into a 2·WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - DIV: restoring division, one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits.
  - At counter==WIDTH-1 go to FIX.
- FIX, 1 cycle, sign correction:
  - MULT: if the result sign is 1, two's-complement negate the 2·WIDTH product.
  - DIV: negate the quotient if the result sign is 1; negate the remainder if sA is 1. The remainder takes the dividend's sign (MIPS semantics).
  - Load hi and lo; go to DONE.
- DONE, 1 cycle:
  - done=1.
  - hi_w=lo_w=1, unless it is the divide-by-zero path.
  - Next edge: IDLE, busy=0, all strobes 0.
- Latency (normal path):
  - Start sampled at E0; done is high in the cycle after edge E0+WIDTH+1 (33 edges for WIDTH=32).
  - busy falls at edge E0+WIDTH+2.
- Latency (divide by zero): done is high in the cycle after E0.
- start while busy: ignored; no queuing.
- Overflow: DIV 0x80000000 / -1 wraps naturally to lo=0x80000000, hi=0, with no flag.
- hi and lo hold their values between operations. They change only in FIX or on reset.
- op, opA, opB are don't-care except at the accepting edge.

Test Plan:
- MULT opA=7, opB=-3 (0xFFFFFFFD) → after 33 edges done=1, hi_w=lo_w=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; next edge busy=0.
- MULT 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000; MULT 0xFFFFFFFF × 0xFFFFFFFF → hi=0, lo=1.
- DIV opA=-7, opB=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVM 100/7 → lo=14, hi=2; DIV 0x80000000/-1 → lo=0x80000000, hi=0.
- DIV opA=5, opB=0 → done=1 and div_zero=1 one cycle after start, hi_w=lo_w=0, hi/lo unchanged from previous result.
- Start MULT, pulse start with DIV at cycle 10 → second request ignored, MULT result delivered at 33; op=00 start → busy stays 0.
- Drop reset_in mid-CALC (cycle 15) → all outputs 0 immediately (asynchronously), no done pulse; release, start MULT 3×4 → lo=12, hi=0 with normal latency.
